conv_row_core: RTL and testbench
================================

Name: conv_row_core

Overview:
- Parametrised successor of the fixed 3x3 row-stationary conv core.
- Streams one input column at a time across NIN input rows, holding a 3-column sliding window.
- Produces NOUT output-row sums per emitted output column.
- Adds configurable vertical/horizontal stride and padding, a stored weight set, valid/ready handshakes with backpressure, a 2-stage pipeline, and optional ReLU. Sits between the line-buffer feeder and the requantiser.

Parameters:
- DW, 8: signed pixel/weight width.
- NOUT, 2: output rows per pass.
- STRIDE, 2: vertical and horizontal stride (1 or 2).
- PAD_TOP, 1: zero row above input row 0 (0/1).
- HPAD, 1: zero column left and right of each row (0/1).
- COLW, 8: output column index width.
- RELU, 0: 1 clamps negative sums to 0.
- Derived: NIN = STRIDE*(NOUT-1)+3-PAD_TOP; ACCW = 2*DW+4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global advance enable; 0 freezes all state.
- w_load  in  1  load weights.
- i_w  in  9*DW  weights, index 3*k+c (k filter row, c filter col), signed.
- i_valid  in  1  input column valid.
- i_ready  out  1  input column accepted when i_valid&i_ready.
- i_col  in  NIN*DW  one column, slice r = input row r, signed.
- i_last  in  1  marks last column of the row.
- o_valid  out  1  output valid.
- o_ready  in  1  downstream accept.
- o_sum  out  NOUT*ACCW  slice o = output row o, signed.
- o_col  out  COLW  output column index within row.

Behaviour:
- Reset: o_valid=0, o_sum=0, o_col=0, i_ready=0, weights=0, window=0, FSM=IDLE, counters=0.
- adv = en & (!o_valid | o_ready). All pipeline and window registers update only when adv.
- i_ready = adv & (state != FLUSH).
- FSM IDLE:
  - Window cleared to zero; virtual column count vcol = HPAD; output column count = 0.
  - w_load latches i_w. w_load is honoured only in IDLE with both pipeline stages empty; it is ignored otherwise.
  - Accept → STREAM, or → IDLE/FLUSH directly if i_last is set on that column.
- FSM STREAM:
  - Each accepted column shifts into the window (oldest dropped); vcol++.
  - Accepted i_last → FLUSH if HPAD=1, else → IDLE.
- FSM FLUSH: on adv, shift in a zero column, vcol++, → IDLE.
- Emit rule (evaluated on each window shift): after the shift, if vcol>=3 and (vcol-3)%STRIDE==0, emit output column j=(vcol-3)/STRIDE.
- Output sum: o_sum[o] = Σ_{k,c} w[k][c]·x[STRIDE*o+k-PAD_TOP][window col c]. Row index -1 (PAD_TOP) is zero.
- Arithmetic: signed products 2*DW, sign-extended to ACCW, 9-term sum. No overflow is possible at ACCW. RELU=1: negative → 0.
- Pipeline:
  - Stage1 registers products plus emit/j.
  - Stage2 registers sums into o_sum/o_col/o_valid.
  - Column accepted at edge t and emitting → o_valid high after edge t+2 when there is no stall.
  - o_valid with o_ready=0: o_sum/o_col held stable, whole pipeline frozen, i_ready=0. No data loss or duplication.
  - o_valid clears on handshake unless a new result advances in the same cycle.
- Rows with W+2*HPAD<3 produce no output; the FSM still returns to IDLE.
- Trailing columns not meeting the emit rule are discarded.
- rst mid-row: immediate return to reset state, and any in-flight outputs are dropped.
- en=0: nothing changes, including handshake state (i_ready=0).

Test Plan:
1. Reset: assert rst 3 cycles with i_valid=1 → o_valid=0, o_sum=0, i_ready=0. First cycle after release in IDLE: i_ready=1.
2. Defaults, center weight w[1][1]=1 (others 0), W=4, x[r][c]=10r+c, o_ready=1 → two outputs: (o_col=0: 0,20), (o_col=1: 2,22). The first appears 2 cycles after the 2nd column is accepted.
3. Defaults, all weights 1, all pixels 1, W=4 → o_col0 = (4,6), o_col1 = (6,9). Checks top and left/right zero padding plus the FLUSH cycle (i_ready=0 for one cycle after i_last).
4. Backpressure: test 3 with o_ready held 0 for 5 cycles at the first o_valid → o_sum/o_col stable, i_ready=0 throughout. Both outputs are delivered exactly once after release.
5. PAD_TOP=0, HPAD=0 (NIN=5), all weights and pixels -128, W=3 → a single output (147456,147456), o_col=0. Then with RELU=1, weights -1, pixels 1 → (0,0).
6. w_load pulsed mid-row with new weights → ignored for that row and the next. Assert rst after 2 columns of a row → o_valid never rises for that row, and the next row computes correctly with reset (zero) weights.

Source files
------------

// File: rtl/conv_row_core.sv
// conv_row_core: row-stationary 3x3 convolution core.
// Streams input columns (NIN rows each) through a 3-column sliding window and
// emits NOUT output-row sums per output column. Window register, product stage
// and sum stage form the pipeline; everything advances together on adv.
module conv_row_core #(
    parameter int DW      = 8,
    parameter int NOUT    = 2,
    parameter int STRIDE  = 2,
    parameter int PAD_TOP = 1,
    parameter int HPAD    = 1,
    parameter int COLW    = 8,
    parameter int RELU    = 0,
    localparam int NIN    = STRIDE*(NOUT-1)+3-PAD_TOP,
    localparam int ACCW   = 2*DW+4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 w_load,
    input  logic [9*DW-1:0]      i_w,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [NIN*DW-1:0]    i_col,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [NOUT*ACCW-1:0] o_sum,
    output logic [COLW-1:0]      o_col
);
    localparam int VW = COLW+2;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                        state;
    logic [8:0][DW-1:0]            w;
    logic [2:0][NIN-1:0][DW-1:0]   win, cur_win, nxt_win;
    logic [NIN-1:0][DW-1:0]        new_col;
    logic [VW-1:0]                 vcol, cur_vcol, nxt_vcol, d;
    logic                          win_emit, s1_emit, emit_c;
    logic [COLW-1:0]               win_j, s1_j;
    logic [NOUT-1:0][8:0][2*DW-1:0] prod_c, s1_prod;
    logic [NOUT-1:0][ACCW-1:0]     sum_c;
    logic                          adv, accept, shift;

    assign adv     = en & (~o_valid | o_ready);
    assign i_ready = adv & ~rst & (state != FLUSH);
    assign accept  = i_ready & i_valid;
    assign shift   = accept | (adv & (state == FLUSH));
    // FLUSH shifts in the right-hand zero pad column
    assign new_col = accept ? i_col : '0;

    // Next window / virtual column; IDLE behaves as a cleared window at vcol=HPAD
    always_comb begin
        cur_win  = (state == IDLE) ? '0 : win;
        cur_vcol = (state == IDLE) ? VW'(HPAD) : vcol;
        nxt_win  = {new_col, cur_win[2], cur_win[1]};
        nxt_vcol = cur_vcol + VW'(1);
        d        = nxt_vcol - VW'(3);
        emit_c   = (nxt_vcol >= VW'(3)) && ((STRIDE == 1) || (d[0] == 1'b0));
    end

    // Products: window column c (0 = oldest), filter row k feeds output row o
    for (genvar o = 0; o < NOUT; o++) begin : g_out
        for (genvar k = 0; k < 3; k++) begin : g_k
            for (genvar c = 0; c < 3; c++) begin : g_c
                localparam int R = STRIDE*o + k - PAD_TOP;
                if (R < 0) begin : g_pad
                    assign prod_c[o][3*k+c] = '0;
                end else begin : g_mul
                    logic [2*DW-1:0] px, wx;
                    assign px = {{DW{win[c][R][DW-1]}}, win[c][R]};
                    assign wx = {{DW{w[3*k+c][DW-1]}}, w[3*k+c]};
                    // low 2*DW bits of the sign-extended product are the signed product
                    assign prod_c[o][3*k+c] = px * wx;
                end
            end
        end
    end

    // Nine-term signed sum per output row, optional ReLU clamp
    always_comb begin
        sum_c = '0;
        for (int o = 0; o < NOUT; o++) begin
            for (int t = 0; t < 9; t++) begin
                sum_c[o] = sum_c[o] + {{(ACCW-2*DW){s1_prod[o][t][2*DW-1]}}, s1_prod[o][t]};
            end
            if (RELU != 0 && sum_c[o][ACCW-1]) sum_c[o] = '0;
        end
    end

    // Row FSM, weight store and sliding window (window acts as pipeline stage 0)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            w        <= '0;
            win      <= '0;
            vcol     <= '0;
            win_emit <= 1'b0;
            win_j    <= '0;
        end else begin
            if (en && state == IDLE && !win_emit && !s1_emit && !o_valid && w_load)
                w <= i_w;
            if (adv) begin
                win_emit <= shift & emit_c;
                win_j    <= COLW'(d >> (STRIDE-1));
                if (shift) begin
                    win  <= nxt_win;
                    vcol <= nxt_vcol;
                end else if (state == IDLE) begin
                    win  <= '0;
                    vcol <= VW'(HPAD);
                end
                case (state)
                    IDLE:    if (accept) state <= i_last ? ((HPAD != 0) ? FLUSH : IDLE) : STREAM;
                    STREAM:  if (accept && i_last) state <= (HPAD != 0) ? FLUSH : IDLE;
                    FLUSH:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage 1: register products with emit flag and output column
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_emit <= 1'b0;
            s1_j    <= '0;
            s1_prod <= '0;
        end else if (adv) begin
            s1_emit <= win_emit;
            s1_j    <= win_j;
            s1_prod <= prod_c;
        end
    end

    // Stage 2: register sums; outputs hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_col   <= '0;
        end else if (adv) begin
            o_valid <= s1_emit;
            if (s1_emit) begin
                o_sum <= sum_c;
                o_col <= s1_j;
            end
        end
    end
endmodule

// File: tb/tb_conv_row_core.sv
// Bench for conv_row_core: directed rows, convolution model + literal pins.
module tb_conv_row_core;
    localparam int ACCW = 20;

    logic        clk = 1'b0;
    logic        rst, en, w_load, i_valid, i_ready, i_last, o_valid, o_ready;
    logic [71:0] i_w;
    logic [31:0] i_col;
    logic [39:0] o_sum;
    logic [7:0]  o_col;

    logic        wl5, v5, l5, rdy5, rdy5r, ov5, ov5r, ordy5;
    logic [71:0] iw5, iw5r;
    logic [39:0] col5, col5r, os5, os5r;
    logic [7:0]  oc5, oc5r;

    conv_row_core dut (
        .clk(clk), .rst(rst), .en(en), .w_load(w_load), .i_w(i_w),
        .i_valid(i_valid), .i_ready(i_ready), .i_col(i_col), .i_last(i_last),
        .o_valid(o_valid), .o_ready(o_ready), .o_sum(o_sum), .o_col(o_col));

    conv_row_core #(.PAD_TOP(0), .HPAD(0)) dut5 (
        .clk(clk), .rst(rst), .en(en), .w_load(wl5), .i_w(iw5),
        .i_valid(v5), .i_ready(rdy5), .i_col(col5), .i_last(l5),
        .o_valid(ov5), .o_ready(ordy5), .o_sum(os5), .o_col(oc5));

    conv_row_core #(.PAD_TOP(0), .HPAD(0), .RELU(1)) dut5r (
        .clk(clk), .rst(rst), .en(en), .w_load(wl5), .i_w(iw5r),
        .i_valid(v5), .i_ready(rdy5r), .i_col(col5r), .i_last(l5),
        .o_valid(ov5r), .o_ready(ordy5), .o_sum(os5r), .o_col(oc5r));

    always #5 clk = ~clk;

    typedef struct {int col; int s0; int s1;} res_t;

    int   checks = 0, errors = 0, cyc = 0;
    int   acc_cyc, acc2, first_cyc;
    int   img [0:3][0:7];
    int   model_w [9];
    bit   stall_req = 1'b0;
    res_t exp_q[$], log_q[$], log5[$], log5r[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sx(input logic [19:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [71:0] packw(input int wv[9]);
        logic [71:0] v;
        for (int t = 0; t < 9; t++) v[t*8 +: 8] = wv[t][7:0];
        return v;
    endfunction

    // Model: 3x3 window at padded column 2j, rows 2o-1..2o+1, zero outside image
    function automatic int conv(input int o, input int j, input int wd);
        int s = 0;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 3; c++) begin
                int r = 2*o + k - 1;
                int x = 2*j + c - 1;
                if (r >= 0 && r < 4 && x >= 0 && x < wd) s += model_w[3*k+c] * img[r][x];
            end
        return s;
    endfunction

    function automatic void expect_row(input int wd);
        res_t e;
        for (int j = 0; 3 + 2*j <= wd + 2; j++) begin
            e.col = j; e.s0 = conv(0, j, wd); e.s1 = conv(1, j, wd);
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_col(input logic [31:0] col, input bit last);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_col = col; i_last = last;
        #1;
        while (!i_ready && n < 100) begin @(negedge clk); #1; n++; end
        if (!i_ready) chk("send_timeout", int'(i_ready), 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_row(input int wd, input bit pulse);
        logic [31:0] col;
        for (int c = 0; c < wd; c++) begin
            for (int r = 0; r < 4; r++) col[r*8 +: 8] = img[r][c][7:0];
            if (pulse && c == 2) begin w_load = 1'b1; i_w = packw('{default: -1}); end
            send_col(col, c == wd-1);
            w_load = 1'b0;
            if (c == 1) acc2 = acc_cyc;
        end
    endtask

    task automatic load_w(input int wv[9]);
        model_w = wv;
        @(negedge clk); w_load = 1'b1; i_w = packw(wv);
        @(negedge clk); w_load = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int idx, input int col, input int s0, input int s1);
        if (idx >= log_q.size()) chk({nm, "_present"}, log_q.size(), idx + 1);
        else begin
            chk({nm, "_col"}, log_q[idx].col, col);
            chk({nm, "_s0"}, log_q[idx].s0, s0);
            chk({nm, "_s1"}, log_q[idx].s1, s1);
        end
    endtask

    // Downstream ready: one 5-cycle stall at the first o_valid when requested
    initial begin
        o_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_req && o_valid) begin
                o_ready = 1'b0; stall_req = 1'b0;
                repeat (5) @(negedge clk);
                o_ready = 1'b1;
            end
        end
    end

    // Compare process: stall stability, and every handshake against the model queue
    initial begin
        bit          have_hold = 1'b0;
        logic [39:0] hsum;
        logic [7:0]  hcol;
        res_t        g, e;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (o_valid && !o_ready) begin
                    if (have_hold) begin
                        chk("hold_sum", int'(o_sum != hsum), 0);
                        chk("hold_col", int'(o_col != hcol), 0);
                    end else begin
                        hsum = o_sum; hcol = o_col; have_hold = 1'b1;
                    end
                    chk("stall_i_ready", int'(i_ready), 0);
                end else have_hold = 1'b0;
                if (o_valid && o_ready) begin
                    g.col = int'(o_col); g.s0 = sx(o_sum[19:0]); g.s1 = sx(o_sum[39:20]);
                    if (log_q.size() == 0) first_cyc = cyc;
                    log_q.push_back(g);
                    if (exp_q.size() == 0) chk("unexpected_out_col", g.col, -1);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_col", g.col, e.col);
                        chk("out_s0", g.s0, e.s0);
                        chk("out_s1", g.s1, e.s1);
                    end
                end
                if (ov5) begin
                    g.col = int'(oc5); g.s0 = sx(os5[19:0]); g.s1 = sx(os5[39:20]);
                    log5.push_back(g);
                end
                if (ov5r) begin
                    g.col = int'(oc5r); g.s0 = sx(os5r[19:0]); g.s1 = sx(os5r[39:20]);
                    log5r.push_back(g);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; w_load = 1'b0; i_w = '0;
        i_valid = 1'b1; i_col = '1; i_last = 1'b0;
        wl5 = 1'b0; iw5 = '0; iw5r = '0; v5 = 1'b0; l5 = 1'b0;
        col5 = '0; col5r = '0; ordy5 = 1'b1;

        // 1. reset held with i_valid asserted
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_o_valid", int'(o_valid), 0);
            chk("rst_o_sum_nz", int'(o_sum != 0), 0);
            chk("rst_i_ready", int'(i_ready), 0);
        end
        rst = 1'b0; i_valid = 1'b0;
        #1;
        chk("idle_i_ready", int'(i_ready), 1);
        chk("rst_o_col", int'(o_col), 0);

        // 2. center weight, x = 10r+c, W=4
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = 10*r + c;
        load_w('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        log_q.delete();
        expect_row(4);
        send_row(4, 1'b0);
        repeat (8) @(negedge clk);
        chk("t2_count", log_q.size(), 2);
        chk_log("t2_o0", 0, 0, 0, 20);
        chk_log("t2_o1", 1, 1, 2, 22);
        chk("t2_latency", first_cyc - acc2, 2);

        // en=0 freezes the handshake
        @(negedge clk); en = 1'b0; #1;
        chk("en0_i_ready", int'(i_ready), 0);
        @(negedge clk); en = 1'b1;

        // 3. all-ones, padding and flush cycle
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = 1;
        load_w('{default: 1});
        log_q.delete();
        expect_row(4);
        send_row(4, 1'b0);
        @(negedge clk); #1;
        chk("flush_i_ready", int'(i_ready), 0);
        @(negedge clk); #1;
        chk("post_flush_i_ready", int'(i_ready), 1);
        repeat (8) @(negedge clk);
        chk("t3_count", log_q.size(), 2);
        chk_log("t3_o0", 0, 0, 4, 6);
        chk_log("t3_o1", 1, 1, 6, 9);

        // 4. same row with a 5-cycle stall at the first output
        stall_req = 1'b1;
        log_q.delete();
        expect_row(4);
        send_row(4, 1'b0);
        repeat (15) @(negedge clk);
        chk("t4_count", log_q.size(), 2);
        chk_log("t4_o0", 0, 0, 4, 6);
        chk_log("t4_o1", 1, 1, 6, 9);
        chk("t4_pending", exp_q.size(), 0);

        // 5. no padding, extreme values; ReLU variant
        @(negedge clk); wl5 = 1'b1; iw5 = {9{8'h80}}; iw5r = {9{8'hFF}};
        @(negedge clk); wl5 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            int n = 0;
            @(negedge clk);
            v5 = 1'b1; l5 = (c == 2); col5 = {5{8'h80}}; col5r = {5{8'h01}};
            #1;
            while (!(rdy5 && rdy5r) && n < 100) begin @(negedge clk); #1; n++; end
            if (!rdy5) chk("t5_send_timeout", int'(rdy5), 1);
            @(posedge clk); #1;
            v5 = 1'b0; l5 = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("t5_count", log5.size(), 1);
        if (log5.size() > 0) begin
            chk("t5_col", log5[0].col, 0);
            chk("t5_s0", log5[0].s0, 147456);
            chk("t5_s1", log5[0].s1, 147456);
        end
        chk("t5r_count", log5r.size(), 1);
        if (log5r.size() > 0) begin
            chk("t5r_s0", log5r[0].s0, 0);
            chk("t5r_s1", log5r[0].s1, 0);
        end

        // 6. w_load mid-row ignored; reset mid-row drops output
        load_w('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = r - c;
        expect_row(5);
        send_row(5, 1'b1);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = c + 1;
        expect_row(4);
        send_row(4, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6_pending", exp_q.size(), 0);
        send_col(32'h04030201, 1'b0);
        send_col(32'h08070605, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_w = '{default: 0};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            chk("t6_rst_o_valid", int'(o_valid), 0);
        end
        log_q.delete();
        expect_row(4);
        send_row(4, 1'b0);
        repeat (8) @(negedge clk);
        chk_log("t6_zero_o0", 0, 0, 0, 0);
        chk_log("t6_zero_o1", 1, 1, 0, 0);
        chk("final_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
